// File: rtl/status_bar_anim.sv
// Status bar renderer for two players: health bar with a draining damage
// trail (ghost), a blinking low-health warning, and a shield strip below.
// Pixel output is registered one clock behind hCount/vCount.
module status_bar_anim #(
    parameter int SEG_W        = 10,
    parameter int LEVELS       = 15,
    parameter int P1_X0        = 192,
    parameter int P2_X0        = 592,
    parameter int BAR_Y0       = 54,
    parameter int BAR_Y1       = 71,
    parameter int SH_Y0        = 75,
    parameter int SH_Y1        = 78,
    parameter int DRAIN_FRAMES = 4,
    parameter int BLINK_FRAMES = 8,
    parameter int LOW_THRESH   = 5,
    parameter int P2_MIRROR    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        frame_tick,
    input  logic [3:0]  p1_health,
    input  logic [3:0]  p1_shield,
    input  logic [3:0]  p2_health,
    input  logic [3:0]  p2_shield,
    output logic [11:0] bar_pixel,
    output logic        bar_draw
);

    localparam int BAR_W = LEVELS * SEG_W;

    localparam logic [3:0] LEVEL_MAX = 4'(LEVELS);
    localparam logic [3:0] LOW_LVL   = 4'(LOW_THRESH);

    localparam int DW = (DRAIN_FRAMES > 1) ? $clog2(DRAIN_FRAMES) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // Geometry at 11 bits so the +2 border never wraps a 10-bit coordinate.
    localparam logic [10:0] SEG_PX = 11'(SEG_W);
    localparam logic [10:0] P1_IL  = 11'(P1_X0);
    localparam logic [10:0] P1_IR  = 11'(P1_X0 + BAR_W);
    localparam logic [10:0] P1_FL  = 11'(P1_X0 - 2);
    localparam logic [10:0] P1_FR  = 11'(P1_X0 + BAR_W + 2);
    localparam logic [10:0] P2_IL  = 11'(P2_X0);
    localparam logic [10:0] P2_IR  = 11'(P2_X0 + BAR_W);
    localparam logic [10:0] P2_FL  = 11'(P2_X0 - 2);
    localparam logic [10:0] P2_FR  = 11'(P2_X0 + BAR_W + 2);
    localparam logic [10:0] BY0    = 11'(BAR_Y0);
    localparam logic [10:0] BY1    = 11'(BAR_Y1);
    localparam logic [10:0] BFY0   = 11'(BAR_Y0 - 2);
    localparam logic [10:0] BFY1   = 11'(BAR_Y1 + 2);
    localparam logic [10:0] SY0    = 11'(SH_Y0);
    localparam logic [10:0] SY1    = 11'(SH_Y1);
    localparam logic [10:0] SFY0   = 11'(SH_Y0 - 2);
    localparam logic [10:0] SFY1   = 11'(SH_Y1 + 2);

    localparam logic [11:0] COL_BLACK   = 12'h000;
    localparam logic [11:0] COL_GREEN   = 12'h0C0;
    localparam logic [11:0] COL_RED     = 12'hF00;
    localparam logic [11:0] COL_DKRED   = 12'h600;
    localparam logic [11:0] COL_YELLOW  = 12'hFF0;
    localparam logic [11:0] COL_PURPLE  = 12'hF0F;
    localparam logic [11:0] COL_WHITE   = 12'hFFF;

    // Index 0 is player 1, index 1 is player 2.
    logic [3:0]    health_in [2];
    logic [3:0]    shield_in [2];

    logic [3:0]    health_q [2];
    logic [3:0]    health_d [2];
    logic [3:0]    shield_q [2];
    logic [3:0]    shield_d [2];
    logic [3:0]    ghost_q  [2];
    logic [3:0]    ghost_d  [2];
    logic [DW-1:0] drain_q  [2];
    logic [DW-1:0] drain_d  [2];

    logic [BW-1:0] blink_cnt_q;
    logic [BW-1:0] blink_cnt_d;
    logic          blink_phase_q;
    logic          blink_phase_d;

    logic [11:0]   pixel_q;
    logic [11:0]   pixel_d;
    logic          draw_q;
    logic          draw_d;

    function automatic logic [3:0] clamp_level(input logic [3:0] lvl);
        return (lvl > LEVEL_MAX) ? LEVEL_MAX : lvl;
    endfunction

    // Health interior colour: live fill first, then the ghost trail, then empty.
    function automatic logic [11:0] health_colour(
        input logic [10:0] off,
        input logic [10:0] hpx,
        input logic [10:0] gpx,
        input logic        low,
        input logic        phase
    );
        logic [11:0] c;
        c = COL_BLACK;
        if (off < hpx) begin
            if (!low) begin
                c = COL_GREEN;
            end else if (phase) begin
                c = COL_RED;
            end else begin
                c = COL_DKRED;
            end
        end else if (off < gpx) begin
            c = COL_YELLOW;
        end
        return c;
    endfunction

    // Gather per-player level inputs into arrays for the loops below.
    always_comb begin
        health_in[0] = p1_health;
        health_in[1] = p2_health;
        shield_in[0] = p1_shield;
        shield_in[1] = p2_shield;
    end

    // Per-frame level latch plus ghost trail: heal snaps up, damage drains slowly.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            health_d[p] = health_q[p];
            shield_d[p] = shield_q[p];
            ghost_d[p]  = ghost_q[p];
            drain_d[p]  = drain_q[p];
            if (frame_tick) begin
                health_d[p] = clamp_level(health_in[p]);
                shield_d[p] = clamp_level(shield_in[p]);
                if (health_d[p] >= ghost_q[p]) begin
                    // Heal wins over a pending drain step.
                    ghost_d[p] = health_d[p];
                    drain_d[p] = '0;
                end else if (drain_q[p] == DRAIN_LAST) begin
                    drain_d[p] = '0;
                    ghost_d[p] = ghost_q[p] - 4'd1;
                end else begin
                    drain_d[p] = drain_q[p] + 1'b1;
                end
                if (ghost_d[p] == health_d[p]) begin
                    drain_d[p] = '0;
                end
            end
        end
    end

    // Frame-rate blink timer for the low-health warning.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Pixel classification: interiors take priority over the white border.
    always_comb begin
        logic [10:0] h_ext;
        logic [10:0] v_ext;
        logic        in_bar_rows;
        logic        in_bar_frows;
        logic        in_sh_rows;
        logic        in_sh_frows;
        logic [10:0] x_lo;
        logic [10:0] x_hi;
        logic [10:0] f_lo;
        logic [10:0] f_hi;
        logic        in_cols;
        logic        in_fcols;
        logic [10:0] off;
        logic [10:0] hpx;
        logic [10:0] gpx;
        logic [10:0] spx;
        logic        low;

        pixel_d = COL_BLACK;
        draw_d  = 1'b0;

        h_ext        = {1'b0, hCount};
        v_ext        = {1'b0, vCount};
        in_bar_rows  = (v_ext >= BY0)  && (v_ext <= BY1);
        in_bar_frows = (v_ext >= BFY0) && (v_ext <= BFY1);
        in_sh_rows   = (v_ext >= SY0)  && (v_ext <= SY1);
        in_sh_frows  = (v_ext >= SFY0) && (v_ext <= SFY1);

        for (int p = 0; p < 2; p++) begin
            x_lo     = (p == 0) ? P1_IL : P2_IL;
            x_hi     = (p == 0) ? P1_IR : P2_IR;
            f_lo     = (p == 0) ? P1_FL : P2_FL;
            f_hi     = (p == 0) ? P1_FR : P2_FR;
            in_cols  = (h_ext >= x_lo) && (h_ext < x_hi);
            in_fcols = (h_ext >= f_lo) && (h_ext < f_hi);

            if ((p == 1) && (P2_MIRROR != 0)) begin
                off = (x_hi - 11'd1) - h_ext;
            end else begin
                off = h_ext - x_lo;
            end

            hpx = 11'(health_q[p]) * SEG_PX;
            gpx = 11'(ghost_q[p])  * SEG_PX;
            spx = 11'(shield_q[p]) * SEG_PX;
            low = (health_q[p] < LOW_LVL);

            if (in_cols && in_bar_rows) begin
                draw_d  = 1'b1;
                pixel_d = health_colour(off, hpx, gpx, low, blink_phase_q);
            end else if (in_cols && in_sh_rows) begin
                draw_d  = 1'b1;
                pixel_d = (off < spx) ? COL_PURPLE : COL_BLACK;
            end else if (in_fcols && (in_bar_frows || in_sh_frows)) begin
                draw_d  = 1'b1;
                pixel_d = COL_WHITE;
            end
        end
    end

    // State and output registers; reset restores full bars and clears any trail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                health_q[p] <= LEVEL_MAX;
                shield_q[p] <= LEVEL_MAX;
                ghost_q[p]  <= LEVEL_MAX;
                drain_q[p]  <= '0;
            end
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            pixel_q       <= COL_BLACK;
            draw_q        <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                health_q[p] <= health_d[p];
                shield_q[p] <= shield_d[p];
                ghost_q[p]  <= ghost_d[p];
                drain_q[p]  <= drain_d[p];
            end
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pixel_q       <= pixel_d;
            draw_q        <= draw_d;
        end
    end

    assign bar_pixel = pixel_q;
    assign bar_draw  = draw_q;

endmodule
